// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and bit-timing helpers
// used by the transmitter, the receiver and the transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    WAIT  = 2'b10
  } arb_state_t;

  // Clock cycles per serial bit; integer division, so the bit period is
  // truncated rather than rounded.
  function automatic int cycles_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter handshake bundle around the UART transmit arbiter.
// The arbiter takes the slave view; whoever drives the requests and models the
// transmitter takes the master view.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WL   = 8
);

  localparam int IDW = idx_width(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*WL-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               tx_start;
  logic [WL-1:0]      tx_data;
  logic               tx_done;
  logic [IDW-1:0]     grant_id;
  logic               active;
  logic               to_err;

  modport slave (
    input  req,
    input  req_data,
    input  tx_done,
    output ack,
    output tx_start,
    output tx_data,
    output grant_id,
    output active,
    output to_err
  );

  modport master (
    output req,
    output req_data,
    output tx_done,
    input  ack,
    input  tx_start,
    input  tx_data,
    input  grant_id,
    input  active,
    input  to_err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request found by
// scanning upward from the slot after `last`, wrapping around. Reusable by
// any arbiter that keeps its own last-winner pointer.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  win,
  output logic            valid
);

  logic [IDW-1:0] idx;

  // Walk last+1 .. last+NREQ modulo NREQ; the first hit wins, so `last`
  // itself is considered only when nobody else is asking.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// A grant acknowledges the winner, launches the transmitter with the latched
// byte and then waits for tx_done; a watchdog gives up on a transmitter that
// never answers.
//
// state | meaning
// IDLE  | scanning requests, nothing in flight
// GRANT | one cycle: ack + tx_start to the winner, watchdog cleared
// WAIT  | byte on the line, waiting for tx_done or watchdog expiry
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int WL        = 8,
  parameter int NREQ      = 4,
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int TO_BITS   = 12
) (
  input logic              CLK,
  input logic              RST_N,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDW    = idx_width(NREQ);
  localparam int TO_CYC = TO_BITS * cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int WDW    = $clog2(TO_CYC + 1);

  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TO_CYC - 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d, wd_inc;
  logic           expire;

  logic [NREQ-1:0] ack_q, ack_d;
  logic            tx_start_q, tx_start_d;
  logic [WL-1:0]   tx_data_q, tx_data_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic            active_q, active_d;
  logic            to_err_q, to_err_d;

  logic [IDW-1:0]  pick_win;
  logic            pick_valid;
  logic [WL-1:0]   pick_data;
  logic [NREQ-1:0] pick_onehot;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (bus.req),
    .last  (last_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // The count after this cycle's increment; expiry is declared when it would
  // land on TO_CYC-1, which puts to_err exactly TO_CYC cycles after GRANT.
  assign wd_inc = wd_q + 1'b1;
  assign expire = (wd_inc == WD_LIMIT);

  // Select the winner's byte and form its one-hot acknowledge
  always_comb begin
    pick_data   = '0;
    pick_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win == IDW'(i)) begin
        pick_data      = bus.req_data[i*WL +: WL];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  // Next state and next registered outputs; tx_data and grant_id hold
  // their last grant's values until the next grant.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wd_d       = wd_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    active_d   = 1'b0;
    to_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          last_d     = pick_win;
          grant_id_d = pick_win;
          tx_data_d  = pick_data;
          ack_d      = pick_onehot;
          tx_start_d = 1'b1;
          active_d   = 1'b1;
        end
      end
      GRANT: begin
        state_d  = WAIT;
        wd_d     = '0;
        active_d = 1'b1;
      end
      WAIT: begin
        wd_d = wd_inc;
        // tx_done takes priority over a watchdog expiry in the same cycle.
        if (bus.tx_done) begin
          state_d = IDLE;
        end else if (expire) begin
          state_d  = IDLE;
          to_err_d = 1'b1;
        end else begin
          active_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, watchdog and output registers; reset aborts any transfer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      last_q     <= LAST_RST;
      wd_q       <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      active_q   <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wd_q       <= wd_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      active_q   <= active_d;
      to_err_q   <= to_err_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant_id = grant_id_q;
  assign bus.active   = active_q;
  assign bus.to_err   = to_err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among NREQ byte requesters. Each requester presents a byte and holds a request. The arbiter grants one requester, acknowledges it, launches the transmitter, and waits for completion before granting again. It sits between the lab's producer blocks (command echo, status reporters) and the single serial transmitter that pairs with the parity-checking receiver. A watchdog recovers from a transmitter that never signals completion.

## Interface
- WL, 8, data word length in bits
- NREQ, 4, number of requesters (2..8)
- CLK_FREQ, 100000000, clock frequency in Hz
- BAUD_RATE, 9600, serial bit rate
- TO_BITS, 12, watchdog length in bit periods
- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request level; held until matching ack
- req_data  in  NREQ*WL  packed bytes; requester i on bits [i*WL +: WL]
- ack  out  NREQ  one-hot, one-cycle pulse; requester's byte accepted
- tx_start  out  1  one-cycle launch pulse to the transmitter
- tx_data  out  WL  byte to transmit; stable from tx_start until return to IDLE
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit
- grant_id  out  clog2(NREQ)  index of the current or last granted requester
- active  out  1  high from GRANT through WAIT
- to_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- Watchdog limit: TO_CYC = TO_BITS * (CLK_FREQ / BAUD_RATE), using integer division. The watchdog counter width is clog2(TO_CYC+1).
- The round-robin pointer `last` resets to NREQ-1, so requester 0 has first priority.
- **IDLE**:
  - If req is nonzero, select the first set bit scanning last+1, last+2, ..., wrapping modulo NREQ.
  - Latch req_data of the winner into tx_data, set grant_id, set last to the winner, and go to GRANT.
  - If req is zero, stay in IDLE.
- **GRANT** (one cycle):
  - ack[grant_id]=1, tx_start=1, active=1.
  - Clear the watchdog counter and go to WAIT.
- **WAIT**:
  - active=1; the watchdog counter increments each cycle.
  - On tx_done=1, go to IDLE.
  - Otherwise, when the counter reaches TO_CYC-1, pulse to_err for one cycle and go to IDLE.
  - If tx_done arrives in the same cycle as expiry, tx_done wins and no to_err is raised.
- tx_done is ignored in IDLE and GRANT.
- Requests from non-granted requesters are not latched. They are re-evaluated in IDLE and do not need to be stable beyond that point.
- A requester that deasserts req before its ack loses its turn silently.
- Bursts are not granted: a requester receives at most one byte per arbitration round while others request.

## Timing
- All outputs are registered.
- Reset values: ack=0, tx_start=0, tx_data=0, grant_id=0, active=0, to_err=0, state=IDLE, last=NREQ-1, watchdog=0.
- Latency: req sampled in IDLE at edge t gives ack and tx_start high during cycle t+1 (GRANT).
- tx_done sampled at edge u puts the block in IDLE for cycle u+1. The next grant is then at u+2.
- Back-to-back throughput is one byte per (transmit time + 3 cycles).
- Asserting RST_N low mid-transfer aborts immediately:
  - All outputs return to reset values and the pointer resets.
  - No ack or to_err is generated.
  - The transmitter is not notified.
- After RST_N rises, the first possible grant is the cycle following the first IDLE sample.

## Structure
- Shared package uart_pkg holds:
  - the state encoding: IDLE=2'b00, GRANT=2'b01, WAIT=2'b10;
  - the function computing cycles per bit from CLK_FREQ and BAUD_RATE, shared with the receiver and transmitter.
- Sub-module rr_pick (combinational): inputs req and last, outputs the winner index and a valid flag. It is reusable for other arbiters in the lab.
- The FSM, data latch, and watchdog remain in uart_tx_arbiter.

## Test plan
- **Single request.** Apply reset, then req=4'b0100 with byte 0xA5 on slot 2. Required response:
  - ack=4'b0100, tx_start, and tx_data=0xA5 in the cycle after sampling, with grant_id=2;
  - after tx_done, no further ack while req is low.
- **Fairness.** Hold req=4'b1111 continuously with distinct bytes 0x10..0x13. Required response:
  - grant order 0,1,2,3,0;
  - tx_data matches each slot's byte.
- **Wrap-around.** Grant requester 3, then present req=4'b1001. The next grant must go to requester 0, not 3.
- **Watchdog.** Use TO_CYC=20 via small parameters and never pulse tx_done. Required response:
  - to_err pulses exactly 20 cycles after GRANT;
  - the state returns to IDLE, and the next request is granted normally.
- **Simultaneous expiry.** Pulse tx_done on the watchdog expiry cycle. The block returns to IDLE with no to_err.
- **Reset mid-transfer.** Drop RST_N during WAIT. Required response:
  - all outputs go to 0 asynchronously;
  - after release with req=4'b0010, requester 1 is granted first because the pointer has reset.
